cordic_vec_ctrl: RTL and testbench

Sequential CORDIC vectoring engine and controller. Given a Cartesian sample (x, y), it computes the angle atan2(y, x) in degrees and the vector magnitude. It drives the address port of the 16-entry arctangent lookup ROM (degrees, 6.10 unsigned) and consumes its combinational data output. It sits between the acoustic phase-difference front end and the USBL bearing-estimation logic, and processes one conversion at a time.

---
 rtl/cordic_vec_ctrl.sv | 130 +++++++++++++
 tb/tb_cordic_vec_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_vec_ctrl.sv
// Purpose: sequential CORDIC vectoring engine; atan2(y,x) in degrees (10.10) and magnitude.
// Latency: NITER+2 cycles from accepted start to done pulse (NITER+3 with CORDIC_GAINCOMP_EN).
// Backpressure: none; start is ignored (never queued) while busy.
module cordic_vec_ctrl #(
    parameter int NITER = 16,
    parameter int INW   = 16,
    parameter int XW    = 19,
    parameter int ZW    = 20
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic signed [INW-1:0] x_in,
    input  logic signed [INW-1:0] y_in,
    output logic [3:0]            rom_addr,
    input  logic [15:0]           rom_data,
    output logic                  busy,
    output logic                  done,
    output logic signed [ZW-1:0]  angle,
    output logic [XW-2:0]         magnitude
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_GAIN, S_OUT} state_t;

    localparam logic [3:0]            LAST = 4'(NITER - 1);
    localparam logic signed [ZW-1:0]  Z90  = ZW'(92160);

    state_t               state;
    logic signed [XW-1:0] xr, yr;
    logic signed [ZW-1:0] zr;
    logic [3:0]           iter;
    logic                 zero_vec;

    logic signed [XW-1:0] xs, ys;
    logic signed [ZW-1:0] rom_ext;

    assign xs       = xr >>> iter;
    assign ys       = yr >>> iter;
    assign rom_ext  = {{(ZW-16){1'b0}}, rom_data};
    // iter is held at zero outside ITER, so it doubles as the ROM address
    assign rom_addr = iter;

`ifdef CORDIC_GAINCOMP_EN
    localparam logic signed [16:0] KINV = 17'sd19898;
    logic signed [XW+16:0] prod;
    assign prod = (XW+17)'(xr) * (XW+17)'(KINV);
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            xr        <= '0;
            yr        <= '0;
            zr        <= '0;
            iter      <= '0;
            zero_vec  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            angle     <= '0;
            magnitude <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        xr       <= XW'(x_in);
                        yr       <= XW'(y_in);
                        zr       <= '0;
                        iter     <= '0;
                        zero_vec <= (x_in == '0) && (y_in == '0);
                        busy     <= 1'b1;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // fold the left half-plane onto the right so the iterations converge
                    if (xr[XW-1]) begin
                        if (!yr[XW-1]) begin
                            xr <= yr;
                            yr <= -xr;
                            zr <= Z90;
                        end else begin
                            xr <= -yr;
                            yr <= xr;
                            zr <= -Z90;
                        end
                    end
                    state <= S_ITER;
                end
                S_ITER: begin
                    if (!yr[XW-1]) begin
                        xr <= xr + ys;
                        yr <= yr - xs;
                        zr <= zr + rom_ext;
                    end else begin
                        xr <= xr - ys;
                        yr <= yr + xs;
                        zr <= zr - rom_ext;
                    end
                    if (iter == LAST) begin
                        iter <= '0;
`ifdef CORDIC_GAINCOMP_EN
                        state <= S_GAIN;
`else
                        state <= S_OUT;
`endif
                    end else begin
                        iter <= iter + 4'd1;
                    end
                end
`ifdef CORDIC_GAINCOMP_EN
                S_GAIN: begin
                    xr    <= prod[XW+14:15];
                    state <= S_OUT;
                end
`endif
                S_OUT: begin
                    // a zero vector still runs every iteration; its z is meaningless
                    angle     <= zero_vec ? '0 : zr;
                    magnitude <= xr[XW-2:0];
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_vec_ctrl.sv
// Scoreboard bench for cordic_vec_ctrl: a bit-exact integer model of the vectoring
// algorithm produces expected angle/magnitude, pushed at start and popped at done.
module tb_cordic_vec_ctrl;

    localparam int NITER = 16;
    localparam int INW   = 16;
    localparam int XW    = 19;
    localparam int ZW    = 20;
`ifdef CORDIC_GAINCOMP_EN
    localparam int  LAT = NITER + 3;
    localparam real KG  = 1.0;
`else
    localparam int  LAT = NITER + 2;
    localparam real KG  = 1.6468;
`endif

    logic                  clock = 1'b0;
    logic                  reset_n;
    logic                  start;
    logic signed [INW-1:0] x_in, y_in;
    logic [3:0]            rom_addr;
    logic [15:0]           rom_data;
    logic                  busy, done;
    logic signed [ZW-1:0]  angle;
    logic [XW-2:0]         magnitude;

    // atan(2^-i) in degrees, 6.10 unsigned, rounded to nearest
    int rom_tab [16] = '{46080, 27203, 14373, 7296, 3662, 1833, 917, 458,
                         229, 115, 57, 29, 14, 7, 4, 2};

    typedef struct {int ang; int mag;} exp_t;
    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    assign rom_data = 16'(rom_tab[rom_addr]);

    always #5 clock = ~clock;

    cordic_vec_ctrl #(.NITER(NITER), .INW(INW), .XW(XW), .ZW(ZW)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .x_in(x_in), .y_in(y_in),
        .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy), .done(done),
        .angle(angle), .magnitude(magnitude)
    );

    function automatic void model(input int xi, input int yi, output int ang, output int mag);
        int x = xi;
        int y = yi;
        int z = 0;
        int xn;
        if (xi == 0 && yi == 0) begin
            ang = 0;
            mag = 0;
            return;
        end
        if (x < 0 && y >= 0) begin
            xn = y; y = -x; x = xn; z = 92160;
        end else if (x < 0 && y < 0) begin
            xn = -y; y = x; x = xn; z = -92160;
        end
        for (int i = 0; i < NITER; i++) begin
            if (y >= 0) begin
                xn = x + (y >>> i); y = y - (x >>> i); z = z + rom_tab[i];
            end else begin
                xn = x - (y >>> i); y = y + (x >>> i); z = z - rom_tab[i];
            end
            x = xn;
        end
`ifdef CORDIC_GAINCOMP_EN
        x = (x * 19898) >>> 15;
`endif
        ang = z;
        mag = x;
    endfunction

    task automatic drive_start(input int xv, input int yv);
        exp_t e;
        int a, m;
        model(xv, yv, a, m);
        e.ang = a;
        e.mag = m;
        sb.push_back(e);
        x_in  = 16'(xv);
        y_in  = 16'(yv);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        x_in  = 16'($urandom);
        y_in  = 16'($urandom);
    endtask

    // Entered one cycle after the accepting edge; returns in the done cycle.
    task automatic wait_done(input string name, input bit chk_hold, input int hold_ang,
                             input int hold_mag, input int pa, input int pb);
        int   c = 0;
        int   rom_err = 0;
        int   hold_err = 0;
        int   er;
        exp_t e;
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL %s busy_rise: got %b want 1", name, busy);
        end
        while (done !== 1'b1 && c < LAT + 20) begin
            er = (c >= 1 && c <= NITER) ? c - 1 : 0;
            if (rom_addr !== 4'(er)) rom_err++;
            if (chk_hold && (angle !== ZW'(hold_ang) || magnitude !== (XW-1)'(hold_mag)))
                hold_err++;
            start = (c == pa || c == pb);
            if (start) begin
                x_in = 16'($urandom);
                y_in = 16'($urandom);
            end
            @(posedge clock); #1;
            c++;
        end
        start = 1'b0;
        total++;
        if (c !== LAT) begin
            bad++; $display("FAIL %s latency: got %0d want %0d", name, c, LAT);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL %s busy_at_done: got %b want 0", name, busy);
        end
        total++;
        if (rom_err !== 0) begin
            bad++; $display("FAIL %s rom_sweep: %0d wrong cycles want 0", name, rom_err);
        end
        if (chk_hold) begin
            total++;
            if (hold_err !== 0) begin
                bad++; $display("FAIL %s hold: %0d cycles changed want 0", name, hold_err);
            end
        end
        total++;
        if (sb.size() == 0) begin
            bad++; $display("FAIL %s scoreboard: empty at done want 1 entry", name);
        end else begin
            e = sb.pop_front();
            if (angle !== ZW'(e.ang)) begin
                bad++; $display("FAIL %s angle: got %0d want %0d", name, angle, e.ang);
            end
            total++;
            if (magnitude !== (XW-1)'(e.mag)) begin
                bad++; $display("FAIL %s magnitude: got %0d want %0d", name, magnitude, e.mag);
            end
        end
    endtask

    task automatic check_approx(input string name, input int xv, input int yv, input int want_ang);
        int  da;
        real want_m, dm;
        da = int'(angle) - want_ang;
        if (da < 0) da = -da;
        total++;
        if (da > 512) begin
            bad++; $display("FAIL %s angle_approx: got %0d want %0d", name, angle, want_ang);
        end
        want_m = KG * $sqrt(real'(xv * xv + yv * yv));
        dm = real'(magnitude) - want_m;
        if (dm < 0.0) dm = -dm;
        total++;
        if (dm > want_m * 0.01 + 2.0) begin
            bad++; $display("FAIL %s mag_approx: got %0d want %0f", name, magnitude, want_m);
        end
    endtask

    task automatic conv(input string name, input int xv, input int yv);
        drive_start(xv, yv);
        wait_done(name, 1'b0, 0, 0, -1, -1);
        @(posedge clock); #1;
        total++;
        if (done !== 1'b0) begin
            bad++; $display("FAIL %s done_pulse: got %b want 0", name, done);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        x_in    = '0;
        y_in    = '0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset done: got %b want 0", done); end
        total++; if (angle !== '0) begin bad++; $display("FAIL reset angle: got %0d want 0", angle); end
        total++; if (magnitude !== '0) begin bad++; $display("FAIL reset mag: got %0d want 0", magnitude); end
        total++; if (rom_addr !== '0) begin bad++; $display("FAIL reset rom_addr: got %0d want 0", rom_addr); end
    endtask

    task automatic test_angles();
        conv("x1000_y0", 1000, 0);        check_approx("x1000_y0", 1000, 0, 0);
        conv("x1000_y1000", 1000, 1000);  check_approx("x1000_y1000", 1000, 1000, 46080);
        conv("xm1000_y0", -1000, 0);      check_approx("xm1000_y0", -1000, 0, 184320);
        conv("x0_ym1000", 0, -1000);      check_approx("x0_ym1000", 0, -1000, -92160);
        conv("zero", 0, 0);
        conv("corner_min", -32768, -32768);
        conv("corner_max", 32767, 32767);
        for (int k = 0; k < 4; k++)
            conv("random", int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
    endtask

    task automatic test_start_ignored();
        int extra = 0;
        drive_start(700, -300);
        wait_done("start_ignored", 1'b0, 0, 0, 3, 10);
        repeat (LAT + 5) begin
            @(posedge clock); #1;
            if (done === 1'b1) extra++;
        end
        total++;
        if (extra !== 0) begin
            bad++; $display("FAIL start_ignored extra_done: got %0d want 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        drive_start(1234, 567);
        repeat (8) begin @(posedge clock); #1; end
        total++;
        if (rom_addr !== 4'd7) begin
            bad++; $display("FAIL reset_mid iter7: got %0d want 7", rom_addr);
        end
        reset_n = 1'b0;
        #1;
        void'(sb.pop_back());
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_mid busy: got %b want 0", busy); end
        total++; if (angle !== '0) begin bad++; $display("FAIL reset_mid angle: got %0d want 0", angle); end
        total++; if (magnitude !== '0) begin bad++; $display("FAIL reset_mid mag: got %0d want 0", magnitude); end
        total++; if (rom_addr !== '0) begin bad++; $display("FAIL reset_mid rom_addr: got %0d want 0", rom_addr); end
        @(posedge clock); #1;
        reset_n = 1'b1;
        repeat (LAT + 6) begin
            @(posedge clock); #1;
            if (done === 1'b1) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++; $display("FAIL reset_mid no_done: got %0d pulses want 0", seen);
        end
        conv("after_reset", 500, -500);
        check_approx("after_reset", 500, -500, -46080);
    endtask

    task automatic test_back_to_back();
        int a1, m1;
        model(1000, 1000, a1, m1);
        drive_start(1000, 1000);
        wait_done("b2b_first", 1'b0, 0, 0, -1, -1);
        drive_start(-700, 300);
        wait_done("b2b_second", 1'b1, a1, m1, -1, -1);
    endtask

    initial begin
        test_reset();
        test_angles();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(posedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
